// File: rtl/alu_seq.sv
// alu_seq: sequential ALU, ADD/SUB/logic/compare in one step, shifts iterated one bit per cycle.
// Latency: 1 cycle for non-shift ops and shamt==0; 1+shamt cycles for shifts (1 cycle with ALU_SEQ_FASTSHIFT_EN).
// Backpressure: in_ready only in IDLE; result/zero held in DONE until out_valid && out_ready.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [SH_W-1:0]   cnt;

    // Single-step ALU. Without the barrel shifter, shift codes only reach
    // this function when shamt is zero, so they simply return A.
    function automatic logic [WIDTH-1:0] alu_comb(
        input logic [3:0]       code,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
`ifdef ALU_SEQ_FASTSHIFT_EN
        logic [SH_W-1:0] sa;
        sa = b[SH_W-1:0];
`endif
        case (code)
            OP_ADD:  alu_comb = a + b;
            OP_SUB:  alu_comb = a - b;
            OP_AND:  alu_comb = a & b;
            OP_OR:   alu_comb = a | b;
            OP_XOR:  alu_comb = a ^ b;
`ifdef ALU_SEQ_FASTSHIFT_EN
            OP_SLL:  alu_comb = a << sa;
            OP_SRL:  alu_comb = a >> sa;
            OP_SRA:  alu_comb = $unsigned($signed(a) >>> sa);
`else
            OP_SLL:  alu_comb = a;
            OP_SRL:  alu_comb = a;
            OP_SRA:  alu_comb = a;
`endif
            OP_SLTU: alu_comb = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLT:  alu_comb = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_comb = '0;
        endcase
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign zero      = (result == '0);

`ifndef ALU_SEQ_FASTSHIFT_EN
    logic [WIDTH-1:0] sh_reg;
    logic [WIDTH-1:0] sh_next;
    logic [3:0]       op_q;
    logic             start_iter;

    // A shift needs the iterative path only when the shift amount is non-zero.
    assign start_iter = (ALU_control == OP_SLL || ALU_control == OP_SRL ||
                         ALU_control == OP_SRA) && (B[SH_W-1:0] != '0);

    // One-bit shift step; SRA replicates the MSB, the others fill with zero.
    always_comb begin
        sh_next = sh_reg;
        case (op_q)
            OP_SLL:  sh_next = {sh_reg[WIDTH-2:0], 1'b0};
            OP_SRL:  sh_next = {1'b0, sh_reg[WIDTH-1:1]};
            OP_SRA:  sh_next = {sh_reg[WIDTH-1], sh_reg[WIDTH-1:1]};
            default: sh_next = sh_reg;
        endcase
    end

    // Shift working registers; captured on acceptance so later input changes are ignored.
    always_ff @(posedge CLK) begin
        if (state == IDLE && in_valid) begin
            sh_reg <= A;
            op_q   <= ALU_control;
        end else if (state == SHIFT) begin
            sh_reg <= sh_next;
        end
    end
`endif

    // Control FSM plus result and shift counter; reset discards any in-flight op.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            result <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef ALU_SEQ_FASTSHIFT_EN
                        result <= alu_comb(ALU_control, A, B);
                        state  <= DONE;
`else
                        if (start_iter) begin
                            cnt   <= B[SH_W-1:0];
                            state <= SHIFT;
                        end else begin
                            result <= alu_comb(ALU_control, A, B);
                            state  <= DONE;
                        end
`endif
                    end
                end
                SHIFT: begin
`ifdef ALU_SEQ_FASTSHIFT_EN
                    state <= IDLE;
`else
                    // Last step lands the shifted value directly in result.
                    cnt <= cnt - SH_W'(1);
                    if (cnt == SH_W'(1)) begin
                        result <= sh_next;
                        state  <= DONE;
                    end
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table-driven bench for alu_seq plus hand-written multi-cycle sequences.
// Latency: expected latencies are the iterative values, collapsed to 1 when ALU_SEQ_FASTSHIFT_EN is set.
// Backpressure: exercises out_ready held low in DONE and reset during an in-flight shift.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0]   code;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        int           lat;
    } vec_t;

    vec_t vecs[16];

    alu_seq #(.WIDTH(W)) dut (
        .CLK        (clk),
        .RESET      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALU_control(ctl),
        .A          (a),
        .B          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] code, input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic [W-1:0] res, input int lat);
        vec_t v;
        v.code = code;
        v.a    = va;
        v.b    = vb;
        v.res  = res;
        v.zero = (res == '0);
`ifdef ALU_SEQ_FASTSHIFT_EN
        v.lat  = 1;
`else
        v.lat  = lat;
`endif
        return v;
    endfunction

    // Issue one request at a negedge, scramble inputs after acceptance, measure latency.
    task automatic issue(input logic [3:0] code, input logic [W-1:0] va, input logic [W-1:0] vb,
                         output int cycles);
        ctl      = code;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ctl      = 4'($urandom_range(0, 15));
        a        = $urandom;
        b        = $urandom;
        cycles   = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!out_valid && cycles <= 100);
    endtask

    initial begin
        int cyc;
        int ov_seen;

        vecs[0]  = mk(4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1);
        vecs[1]  = mk(4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
        vecs[2]  = mk(4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
        vecs[3]  = mk(4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 5);
        vecs[4]  = mk(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
        vecs[5]  = mk(4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1);
        vecs[6]  = mk(4'b0011, 32'h0000_FF00, 32'h00FF_0000, 32'h00FF_FF00, 1);
        vecs[7]  = mk(4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
        vecs[8]  = mk(4'b0101, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 32);
        vecs[9]  = mk(4'b0110, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 5);
        vecs[10] = mk(4'b0101, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1);
        vecs[11] = mk(4'b1111, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_0000, 1);
        vecs[12] = mk(4'b0111, 32'h7FFF_FFFF, 32'h0000_0003, 32'h0FFF_FFFF, 4);
        vecs[13] = mk(4'b0001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1);
        vecs[14] = mk(4'b1001, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        vecs[15] = mk(4'b1000, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0001, 1);

        // Reset with a simultaneous request: reset must win.
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        ctl       = 4'b0000;
        a         = 32'h1;
        b         = 32'h1;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);

        // Table-driven vectors, out_ready high.
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].code, vecs[i].a, vecs[i].b, cyc);
            chk($sformatf("v%0d_latency", i), cyc, vecs[i].lat);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_zero", i), zero, vecs[i].zero);
            @(negedge clk);
            chk($sformatf("v%0d_in_ready_after", i), in_ready, 1);
            chk($sformatf("v%0d_out_valid_after", i), out_valid, 0);
        end

        // Backpressure: ADD 3+4 held in DONE for three cycles with a stray request present.
        out_ready = 1'b0;
        issue(4'b0000, 32'd3, 32'd4, cyc);
        chk("bp_latency", cyc, 1);
        in_valid = 1'b1;
        ctl      = 4'b0001;
        a        = 32'd100;
        b        = 32'd1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_hold%0d_valid", k), out_valid, 1);
            chk($sformatf("bp_hold%0d_result", k), result, 32'd7);
            chk($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
            @(negedge clk);
        end
        chk("bp_hs_in_ready", in_ready, 0);
        chk("bp_hs_result", result, 32'd7);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_after_in_ready", in_ready, 1);
        chk("bp_after_out_valid", out_valid, 0);
        chk("bp_after_result", result, 32'd7);
        @(negedge clk);
        chk("bp_no_reaccept", out_valid, 0);

        // Reset mid-op: SLL 1<<31, reset 10 cycles after acceptance.
        out_ready = 1'b0;
        ctl       = 4'b0101;
        a         = 32'h1;
        b         = 32'd31;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ov_seen  = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
`ifdef ALU_SEQ_FASTSHIFT_EN
        chk("rm_pre_reset_valid_cycles", ov_seen, 10);
`else
        chk("rm_pre_reset_valid_cycles", ov_seen, 0);
`endif
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rm_out_valid", out_valid, 0);
        chk("rm_result", result, 0);
        chk("rm_zero", zero, 1);
        chk("rm_in_ready", in_ready, 1);
        ov_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        chk("rm_no_late_valid", ov_seen, 0);

        // Fresh operation after the discarded one still works.
        issue(4'b0110, 32'hF000_0000, 32'd2, cyc);
`ifdef ALU_SEQ_FASTSHIFT_EN
        chk("post_rst_latency", cyc, 1);
`else
        chk("post_rst_latency", cyc, 3);
`endif
        chk("post_rst_result", result, 32'h3C00_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
